fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_W, default 4; instruction-address width in words.
REQ-002 Parameter DATA_W, default 32; instruction width.
REQ-003 Parameter RESET_PC, default 0; first address fetched after reset.
REQ-004 Parameter CNT_W, default 16; width of the accepted-instruction counter.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  decode not ready; the current output is held.
REQ-008 redirect  in  1  jump/branch taken; replaces the PC.
REQ-009 redirect_addr  in  ADDR_W  jump/branch target.
REQ-010 halt_req  in  1  level request to stop fetching.
REQ-011 imem_addr  out  ADDR_W  address to the synchronous instruction RAM (1-cycle read latency).
REQ-012 imem_rdata  in  DATA_W  RAM read data for the address presented on the previous edge.
REQ-013 instr  out  DATA_W  fetched instruction; combinational pass-through of imem_rdata.
REQ-014 instr_valid  out  1  instr/instr_pc hold a correct-path instruction.
REQ-015 instr_pc  out  ADDR_W  address of instr.
REQ-016 pc_plus1  out  ADDR_W  instr_pc+1 modulo 2^ADDR_W.
REQ-017 halted  out  1  high while in HALT.
REQ-018 fetch_count  out  CNT_W  number of accepted instructions.

Function
REQ-019 Internal registers: pc (next address to issue), f_pc (address in flight), f_valid, state, and count.
REQ-020 FSM states: FILL (issue only, output invalid), RUN, HALT.
REQ-021 imem_addr is combinational: f_pc when state=RUN and stall=1; otherwise pc. A stalled RAM therefore re-reads f_pc, so instr stays stable.
REQ-022 Event priority within a cycle: redirect > halt_req > stall.
REQ-023 FILL, no redirect: f_pc<=pc, pc<=pc+1, f_valid<=1, next state RUN; stall is ignored.
REQ-024 RUN, no stall, no redirect, no halt_req: f_pc<=pc, pc<=pc+1, f_valid stays 1.
REQ-025 An instruction is accepted when state=RUN, f_valid=1 and stall=0; each acceptance increments fetch_count.
REQ-026 RUN with stall=1 (and no redirect or halt_req): pc, f_pc, f_valid, state and count all hold.
REQ-027 Redirect in any state: pc<=redirect_addr and f_valid<=0.
REQ-028 Next state after a redirect is FILL, or HALT if halt_req=1; the instruction shown that cycle is not counted.
REQ-029 RUN, halt_req=1, no redirect: counts the current instruction if stall=0, then f_valid<=0 and state<=HALT; pc holds, so the unissued address is refetched on resume.
REQ-030 HALT: imem_addr=pc and f_valid=0; halt_req=0 moves the FSM to FILL.
REQ-031 PC arithmetic is modulo 2^ADDR_W: increment from all-ones wraps to 0 with no flag.
REQ-032 fetch_count wraps at 2^CNT_W with no saturation.
REQ-033 Latency: an address issued on edge N appears as valid instr after edge N+1; a redirect costs exactly one invalid cycle (FILL).
REQ-034 instr_valid=f_valid, instr_pc=f_pc and halted=(state==HALT), all without added logic delay beyond decode.

Reset
REQ-035 Asserting reset_n=0 immediately sets pc=RESET_PC, f_pc=RESET_PC, f_valid=0, state=FILL and count=0, regardless of clk.
REQ-036 During reset, outputs read: instr_valid=0, instr_pc=RESET_PC, pc_plus1=RESET_PC+1, halted=0, fetch_count=0, imem_addr=RESET_PC.
REQ-037 Reset mid-stall or mid-redirect discards all in-flight state; the first valid instruction is RESET_PC, one edge after reset release.

Structure
REQ-038 The state encoding (FILL/RUN/HALT) and the RESET_PC default belong in the shared CPU package.
REQ-039 One sub-module is natural: fetch_pc_reg, holding the pc/f_pc/f_valid pipeline register with its redirect and stall muxing; the FSM and counter stay in fetch_stage.
REQ-040 The RAM is external; fetch_stage contains no memory array.

Verification
REQ-041 Reset release, RAM[i]=i+0x100, no stall: instr_pc 0,1,2,3 on consecutive cycles, instr 0x100..0x103, fetch_count=4 after 4 accepts.
REQ-042 Stall held 3 cycles while instr_pc=2: instr_pc=2, instr=0x102 and fetch_count constant throughout; imem_addr=2 during the stall; instr_pc=3 the cycle after release.
REQ-043 Redirect to 0x9 while instr_pc=4: the next cycle has instr_valid=0, the one after instr_pc=9 with valid=1; address 5 is never accepted.
REQ-044 With ADDR_W=4, sequential run through 0xF: the next instr_pc is 0x0 and pc_plus1 at 0xF is 0x0.
REQ-045 halt_req asserted at instr_pc=6 (no stall): 6 is counted, halted=1, instr_valid=0; after release, one FILL cycle, then instr_pc=7.
REQ-046 redirect and stall together at instr_pc=3 with target 0xC: the redirect wins, fetch_count is unchanged, and the next valid instr_pc is 0xC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared CPU package: fetch FSM encoding and reset vector
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - pc / f_pc / f_valid pipeline register with redirect and stall muxing
module fetch_pc_reg #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              flush,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] f_pc,
    output logic              f_valid
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    // Priority redirect > flush > advance; with none of them everything holds (stall).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RST_PC;
            f_pc    <= RST_PC;
            f_valid <= 1'b0;
        end else if (redirect) begin
            pc      <= redirect_addr;
            f_valid <= 1'b0;
        end else if (flush) begin
            f_valid <= 1'b0;
        end else if (advance) begin
            f_pc    <= pc;
            pc      <= pc + ADDR_W'(1);
            f_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: FILL/RUN/HALT control, PC pipeline and accept counter
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    fetch_state_t      state, state_nxt;
    logic              advance, flush, accept;
    logic [ADDR_W-1:0] pc, f_pc;
    logic              f_valid;
    logic [CNT_W-1:0]  count;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset_n       (reset_n),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .flush         (flush),
        .advance       (advance),
        .pc            (pc),
        .f_pc          (f_pc),
        .f_valid       (f_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_FILL;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        flush     = 1'b0;
        if (redirect) begin
            state_nxt = halt_req ? ST_HALT : ST_FILL;
        end else if (halt_req) begin
            flush     = 1'b1;
            state_nxt = ST_HALT;
        end else begin
            case (state)
                ST_FILL: begin
                    advance   = 1'b1;
                    state_nxt = ST_RUN;
                end
                ST_RUN:  advance   = !stall;
                ST_HALT: state_nxt = ST_FILL;
                default: state_nxt = ST_FILL;
            endcase
        end
    end

    // A redirect squashes the instruction on display, so it is never counted.
    assign accept = (state == ST_RUN) && f_valid && !stall && !redirect;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    count <= '0;
        else if (accept) count <= count + CNT_W'(1);
    end

    // A stalled RAM re-reads the displayed address so instr stays stable.
    assign imem_addr   = (state == ST_RUN && stall) ? f_pc : pc;
    assign instr       = imem_rdata;
    assign instr_valid = f_valid;
    assign instr_pc    = f_pc;
    assign pc_plus1    = f_pc + ADDR_W'(1);
    assign halted      = (state == ST_HALT);
    assign fetch_count = count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a behavioural fetch model
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [3:0]  redirect_addr = '0;
    logic        halt_req = 1'b0;
    logic [3:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [3:0]  instr_pc;
    logic [3:0]  pc_plus1;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [16];
    int errors = 0;
    int checks = 0;

    // Model: next address to issue, address on display, whether it is real,
    // the phase (0 = refilling, 1 = streaming, 2 = halted) and the accept count.
    int unsigned m_next, m_show, m_cnt;
    bit          m_shown;
    int          m_phase;

    fetch_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt_req      (halt_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_pc      (instr_pc),
        .pc_plus1      (pc_plus1),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic model_reset();
        m_next = 0; m_show = 0; m_cnt = 0; m_shown = 0; m_phase = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_phase == 1 && m_shown && !stall && !redirect) m_cnt = (m_cnt + 1) % 65536;
        if (redirect) begin
            m_next  = redirect_addr;
            m_shown = 0;
            m_phase = halt_req ? 2 : 0;
        end else if (halt_req) begin
            m_shown = 0;
            m_phase = 2;
        end else if (m_phase == 0) begin
            m_show = m_next; m_next = (m_next + 1) % 16; m_shown = 1; m_phase = 1;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (!stall) begin
            m_show = m_next; m_next = (m_next + 1) % 16;
        end
        @(negedge clk);
    endtask

    task automatic set_in(input bit s, input bit r, input int unsigned a, input bit h);
        stall = s; redirect = r; redirect_addr = 4'(a); halt_req = h;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
        checks++; if (instr_pc !== 4'd0) begin errors++; $display("FAIL reset_pc got=%0h exp=0", instr_pc); end
        checks++; if (pc_plus1 !== 4'd1) begin errors++; $display("FAIL reset_pc_plus1 got=%0h exp=1", pc_plus1); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%0b exp=0", halted); end
        checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        checks++; if (imem_addr !== 4'd0) begin errors++; $display("FAIL reset_imem_addr got=%0h exp=0", imem_addr); end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 4'(i)) begin
                errors++; $display("FAIL seq_pc got=%0h/%0b exp=%0h/1", instr_pc, instr_valid, i);
            end
            checks++; if (instr !== 32'h100 + i) begin errors++; $display("FAIL seq_instr got=%0h exp=%0h", instr, 32'h100 + i); end
            tick();
        end
        checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL seq_count got=%0d exp=4", fetch_count); end
    endtask

    task automatic test_stall();
        do_reset();
        run(3);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0);
            #1;
            checks++; if (instr_pc !== 4'd2 || instr !== 32'h102) begin
                errors++; $display("FAIL stall_hold got=%0h/%0h exp=2/102", instr_pc, instr);
            end
            checks++; if (fetch_count !== 16'd2) begin errors++; $display("FAIL stall_count got=%0d exp=2", fetch_count); end
            checks++; if (imem_addr !== 4'd2) begin errors++; $display("FAIL stall_imem_addr got=%0h exp=2", imem_addr); end
            tick();
        end
        set_in(0, 0, 0, 0);
        tick();
        checks++; if (instr_pc !== 4'd3 || instr_valid !== 1'b1 || fetch_count !== 16'd3) begin
            errors++; $display("FAIL stall_release got=%0h/%0b/%0d exp=3/1/3", instr_pc, instr_valid, fetch_count);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        run(5);
        set_in(0, 1, 9, 0);
        tick();
        set_in(0, 0, 0, 0);
        checks++; if (instr_valid !== 1'b0 || fetch_count !== 16'd4) begin
            errors++; $display("FAIL redir_bubble got=%0b/%0d exp=0/4", instr_valid, fetch_count);
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 4'd9 || instr !== 32'h109) begin
            errors++; $display("FAIL redir_target got=%0b/%0h/%0h exp=1/9/109", instr_valid, instr_pc, instr);
        end
        tick();
        checks++; if (fetch_count !== 16'd5) begin errors++; $display("FAIL redir_count got=%0d exp=5", fetch_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        run(16);
        checks++; if (instr_pc !== 4'hF || pc_plus1 !== 4'h0) begin
            errors++; $display("FAIL wrap_plus1 got=%0h/%0h exp=f/0", instr_pc, pc_plus1);
        end
        tick();
        checks++; if (instr_pc !== 4'h0 || instr !== 32'h100 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_next got=%0h/%0h exp=0/100", instr_pc, instr);
        end
    endtask

    task automatic test_halt();
        do_reset();
        run(7);
        set_in(0, 0, 0, 1);
        tick();
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || fetch_count !== 16'd7) begin
            errors++; $display("FAIL halt_enter got=%0b/%0b/%0d exp=1/0/7", halted, instr_valid, fetch_count);
        end
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold got=%0b exp=1", halted); end
        set_in(0, 0, 0, 0);
        tick();
        checks++; if (halted !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL halt_fill got=%0b/%0b exp=0/0", halted, instr_valid);
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 4'd7 || instr !== 32'h107) begin
            errors++; $display("FAIL halt_resume got=%0b/%0h exp=1/7", instr_valid, instr_pc);
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        run(4);
        set_in(1, 1, 12, 0);
        tick();
        set_in(0, 0, 0, 0);
        checks++; if (instr_valid !== 1'b0 || fetch_count !== 16'd3) begin
            errors++; $display("FAIL redstall_bubble got=%0b/%0d exp=0/3", instr_valid, fetch_count);
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 4'hC || instr !== 32'h10C) begin
            errors++; $display("FAIL redstall_target got=%0b/%0h exp=1/c", instr_valid, instr_pc);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        run(3);
        set_in(1, 0, 0, 0);
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || fetch_count !== 16'd0) begin
            errors++; $display("FAIL midreset_clear got=%0b/%0d exp=0/0", instr_valid, fetch_count);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0);
        reset_n = 1'b1;
        model_reset();
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 4'd0 || instr !== 32'h100) begin
            errors++; $display("FAIL midreset_first got=%0b/%0h/%0h exp=1/0/100", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_random();
        int unsigned exp_addr;
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10,
                   $urandom_range(0, 15), $urandom_range(0, 99) < 8);
            #1;
            exp_addr = (m_phase == 1 && stall) ? m_show : m_next;
            checks++; if (instr_valid !== m_shown) begin errors++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, instr_valid, m_shown); end
            checks++; if (halted !== (m_phase == 2)) begin errors++; $display("FAIL rnd_halted n=%0d got=%0b exp=%0b", n, halted, m_phase == 2); end
            checks++; if (fetch_count !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, fetch_count, m_cnt); end
            checks++; if (imem_addr !== 4'(exp_addr)) begin errors++; $display("FAIL rnd_imem_addr n=%0d got=%0h exp=%0h", n, imem_addr, exp_addr); end
            if (m_shown) begin
                checks++; if (instr_pc !== 4'(m_show)) begin errors++; $display("FAIL rnd_pc n=%0d got=%0h exp=%0h", n, instr_pc, m_show); end
                checks++; if (pc_plus1 !== 4'((m_show + 1) % 16)) begin errors++; $display("FAIL rnd_plus1 n=%0d got=%0h exp=%0h", n, pc_plus1, (m_show + 1) % 16); end
                checks++; if (instr !== mem[m_show]) begin errors++; $display("FAIL rnd_instr n=%0d got=%0h exp=%0h", n, instr, mem[m_show]); end
            end
            tick();
        end
        set_in(0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_redirect_stall();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
